tdm_demux: RTL
==============

// Module: tdm_demux
// PURPOSE
//   Receive end of the generic 2**N:1 mux path. A serial bit stream, produced by
//   a mux whose select steps 0..2**N-1, is rebuilt into the full 2**N-bit word.
//   Slot i of a frame lands in out[i], so a mux/demux round trip returns the original input.
//   Sits after the mux, or after a serial link carrying its output, in the datapath.
// PARAMETERS
//   N   4   select width; frame length W = 2**N slots/bits
// PORTS
//   clk          in   1     system clock, rising edge
//   rst          in   1     reset, asynchronous, active-high
//   din          in   1     serial data bit (mux output)
//   din_valid    in   1     din valid this cycle; slot advances only when high
//   frame_start  in   1     qualifies din as slot 0 of a new frame (needs din_valid)
//   slot         out  N     index of next slot to be written (debug/monitor)
//   out          out  W     last completed frame, bit i = slot i
//   out_valid    out  1     one-cycle pulse: out updated with a new frame
//   sync_err     out  1     one-cycle pulse: frame_start arrived mid-frame
// BEHAVIOUR
//   Reset (async, active-high): state=HUNT, slot=0, shadow=0, out=0, out_valid=0,
//     sync_err=0. Reset mid-frame discards the partial frame; out is cleared.
//   FSM states: HUNT (no frame alignment), COLLECT (mid-frame).
//   Sampling only on edges where din_valid=1; din_valid=0 holds all state.
//     frame_start with din_valid=0 is ignored.
//   HUNT: din_valid&frame_start -> shadow[0]<=din, slot<=1, go COLLECT;
//     other valid bits are dropped, slot stays 0.
//   COLLECT, din_valid, !frame_start: shadow[slot]<=din, slot<=slot+1 (mod W).
//     Last slot (slot==W-1): out<={din,shadow[W-2:0]}; out_valid=1 for the
//     following cycle; slot wraps to 0; stays in COLLECT.
//   COLLECT, slot==0, din_valid&frame_start: normal back-to-back frame start,
//     no error.
//   COLLECT, slot!=0, din_valid&frame_start: sync_err=1 for one cycle; partial
//     frame discarded (out unchanged); shadow[0]<=din, slot<=1 (resync).
//   COLLECT, slot==0, valid bit without frame_start: accepted as slot 0 (free-run
//     framing after lock).
//   Latency: out/out_valid are registered on the edge that samples slot W-1.
//     They are visible the cycle after that bit is presented.
//   out holds its value between frames. out_valid never lasts over 1 cycle.
//     out_valid and sync_err are never high in the same cycle.
//   N=1 is legal (W=2); slot arithmetic is N bits wide and wraps naturally.
// STRUCTURE
//   Package tdm_pkg: typedef enum logic {HUNT, COLLECT} tdm_state_t; a
//     localparam for default N.
//   Sub-module tdm_slot_counter: N-bit counter with enable, load-to-1 and
//     last-slot flag (cnt==W-1).
//   Top holds FSM, W-1-bit shadow register, output register and pulse flops.
// TESTING
//   1 Reset then 16 valid bits of 16'hA607, LSB first, frame_start on bit 0 ->
//     out=16'hA607 and one out_valid pulse after the 16th bit.
//   2 Same frame with din_valid low for 3 cycles between bits 5 and 6 ->
//     out=16'hA607, slot frozen at 6 during the gap.
//   3 Frame 16'hA607 back-to-back with 16'h5AF0, no idle cycles ->
//     out_valid pulses exactly 16 cycles apart, values A607 then 5AF0.
//   4 frame_start at slot 9, then a full frame of 16'h1234 -> sync_err pulses
//     once, out stays A607, then out=1234 with no sync_err.
//   5 Valid bits with no frame_start after reset -> slot=0, no out_valid, out=0.
//   6 Assert rst at slot 7 -> out=0 and slot=0 immediately (async); next frame
//     of 16'hFFFF decodes correctly.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM receive path.
package tdm_pkg;

   // Frame alignment state: HUNT until a frame_start is seen, COLLECT once locked.
   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } tdm_state_t;

   // Default select width; frame length is 2**N slots.
   localparam int TDM_N_DEFAULT = 4;

endpackage

// File: rtl/tdm_slot_counter.sv
// N-bit slot counter: load-to-1 on frame start, increment on enable,
// wraps naturally at 2**N, flags the last slot of the frame.
module tdm_slot_counter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic         i_load1,
   output logic [N-1:0] o_cnt,
   output logic         o_last
);

   logic [N-1:0] r_cnt;

   // Slot register; a frame start always lands the next write at slot 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load1) begin
         r_cnt <= N'(1);
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_last = (r_cnt == {N{1'b1}});

endmodule

// File: rtl/tdm_demux.sv
// Rebuilds a 2**N-bit word from the serial stream of a TDM mux.
// Slot i of a frame lands in out[i]; out_valid pulses once per completed frame.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int N = TDM_N_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              din_valid,
   input  logic              frame_start,
   output logic [N-1:0]      slot,
   output logic [(2**N)-1:0] out,
   output logic              out_valid,
   output logic              sync_err
);

   localparam int W = 2 ** N;

   tdm_state_t   r_state;
   tdm_state_t   w_state_next;
   logic [N-1:0] w_slot;
   logic         w_last;
   logic         w_cnt_en;
   logic         w_cnt_load1;
   logic         w_wr_start;
   logic         w_wr_slot;
   logic         w_frame_done;
   logic         w_sync_err;
   logic [W-2:0] r_shadow;
   logic [W-1:0] r_out;
   logic         r_out_valid;
   logic         r_sync_err;

   tdm_slot_counter #(
      .N (N)
   ) u_slot_counter (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_cnt_en),
      .i_load1 (w_cnt_load1),
      .o_cnt   (w_slot),
      .o_last  (w_last)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= HUNT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: any qualified frame_start gives alignment; lock is never dropped.
   always_comb begin
      w_state_next = r_state;
      if (din_valid && frame_start) begin
         w_state_next = COLLECT;
      end
   end

   // Datapath controls: frame_start restarts the frame from slot 0 (flagging an
   // error if it cuts a partial frame); otherwise bits are taken only once locked.
   always_comb begin
      w_cnt_en     = 1'b0;
      w_cnt_load1  = 1'b0;
      w_wr_start   = 1'b0;
      w_wr_slot    = 1'b0;
      w_frame_done = 1'b0;
      w_sync_err   = 1'b0;
      if (din_valid) begin
         if (frame_start) begin
            w_cnt_load1 = 1'b1;
            w_wr_start  = 1'b1;
            w_sync_err  = (r_state == COLLECT) && (w_slot != '0);
         end else if (r_state == COLLECT) begin
            w_cnt_en     = 1'b1;
            w_wr_slot    = 1'b1;
            w_frame_done = w_last;
         end
      end
   end

   // Shadow bits for slots 0..W-2; the last slot goes straight into out.
   generate
      for (genvar gi = 0; gi < W - 1; gi++) begin : g_shadow
         // Capture din into this slot's shadow bit when it is the slot being written.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_shadow[gi] <= 1'b0;
            end else if ((w_wr_start && (gi == 0)) ||
                         (w_wr_slot && (w_slot == N'(gi)))) begin
               r_shadow[gi] <= din;
            end
         end
      end
   endgenerate

   // Output word and one-cycle status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_sync_err  <= 1'b0;
      end else begin
         if (w_frame_done) begin
            r_out <= {din, r_shadow};
         end
         r_out_valid <= w_frame_done;
         r_sync_err  <= w_sync_err;
      end
   end

   assign slot      = w_slot;
   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign sync_err  = r_sync_err;

endmodule
